free_list_queue: RTL and testbench

Parametrised circular free list of physical register tags, the successor to the flat multiport free-list RAM. It owns its head and tail pointers and occupancy count, and initialises itself to a full list on reset. It hands out up to ALLOC_WIDTH tags per cycle to rename/dispatch and accepts up to FREE_WIDTH released tags per cycle from commit. Allocation is all-or-nothing with a stall output, and a sticky error flag reports over-free.

---
 rtl/free_list_queue_if.sv | 30 +++
 rtl/free_list_queue.sv | 96 +++++++++
 tb/tb_free_list_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/free_list_queue_if.sv
// Allocation/free bundle between rename, commit and the free list.
interface free_list_queue_if #(
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int INDEX       = 5,
  parameter int WIDTH       = 7
);
  logic [ALLOC_WIDTH-1:0]       alloc_valid_i;
  logic                         alloc_en_i;
  logic [ALLOC_WIDTH*WIDTH-1:0] alloc_tag_o;
  logic                         stall_o;
  logic [FREE_WIDTH-1:0]        free_valid_i;
  logic [FREE_WIDTH*WIDTH-1:0]  free_tag_i;
  logic [INDEX:0]               count_o;
  logic                         overflow_o;

  modport master (
    output alloc_valid_i, alloc_en_i,
    output free_valid_i, free_tag_i,
    input  alloc_tag_o, stall_o,
    input  count_o, overflow_o
  );

  modport slave (
    input  alloc_valid_i, alloc_en_i,
    input  free_valid_i, free_tag_i,
    output alloc_tag_o, stall_o,
    output count_o, overflow_o
  );
endinterface

// File: rtl/free_list_queue.sv
// Circular free list of physical register tags.
// Compacted multi-lane allocate from head, compacted free at tail.
module free_list_queue #(
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int DEPTH       = 32,
  parameter int INDEX       = 5,
  parameter int WIDTH       = 7,
  parameter int TAG_BASE    = 32
) (
  input logic clk,
  input logic reset,
  free_list_queue_if.slave bus
);

  localparam logic [INDEX:0] DEPTH_C = (INDEX+1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [INDEX-1:0] head;
  logic [INDEX-1:0] tail;
  logic [INDEX:0]   count;
  logic             overflow;

  logic [INDEX:0] rank_a [ALLOC_WIDTH];
  logic [INDEX:0] rank_f [FREE_WIDTH];
  logic [FREE_WIDTH-1:0] accept;
  logic [INDEX:0] a_cnt;
  logic [INDEX:0] a_eff;
  logic [INDEX:0] f_cnt;
  logic [INDEX:0] avail;
  logic [INDEX:0] room;
  logic           stall;
  logic           fire;
  logic           ovf_hit;

  always_comb begin
    a_cnt = '0;
    bus.alloc_tag_o = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      rank_a[k] = a_cnt;
      bus.alloc_tag_o[k*WIDTH +: WIDTH] =
        ram[head + rank_a[k][INDEX-1:0]];
      a_cnt = a_cnt + (INDEX+1)'(bus.alloc_valid_i[k]);
    end
    stall = count < a_cnt;
    fire  = bus.alloc_en_i && !stall;
    a_eff = fire ? a_cnt : '0;
    avail = count - a_eff;
    room  = DEPTH_C - avail;
    // lowest-ranked frees win whatever room remains
    f_cnt   = '0;
    ovf_hit = 1'b0;
    accept  = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      rank_f[j] = f_cnt;
      if (bus.free_valid_i[j]) begin
        if (f_cnt < room) begin
          accept[j] = 1'b1;
          f_cnt = f_cnt + 1'b1;
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= WIDTH'(TAG_BASE + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= DEPTH_C;
      overflow <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (accept[j]) begin
          ram[tail + rank_f[j][INDEX-1:0]] <=
            bus.free_tag_i[j*WIDTH +: WIDTH];
        end
      end
      head  <= head + a_eff[INDEX-1:0];
      tail  <= tail + f_cnt[INDEX-1:0];
      count <= avail + f_cnt;
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.stall_o    = stall;
  assign bus.count_o    = count;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_free_list_queue.sv
// Directed bench for free_list_queue.
// Inputs change after posedge; outputs sampled mid-cycle.
module tb_free_list_queue;

  localparam int AW = 4;
  localparam int FW = 4;
  localparam int W  = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  free_list_queue_if #(
    .ALLOC_WIDTH(AW), .FREE_WIDTH(FW), .INDEX(5), .WIDTH(W)
  ) bus ();

  free_list_queue dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return 32'(bus.alloc_tag_o[k*W +: W]);
  endfunction

  task automatic idle();
    bus.alloc_valid_i = '0;
    bus.alloc_en_i    = 1'b0;
    bus.free_valid_i  = '0;
    bus.free_tag_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic set_free(input int j, input int t);
    bus.free_valid_i[j] = 1'b1;
    bus.free_tag_i[j*W +: W] = W'(t);
  endtask

  initial begin
    idle();

    // reset state and full 4-lane allocate
    do_reset();
    bus.alloc_valid_i = 4'b1111;
    #1;
    chk("rst_count", 32'(bus.count_o), 32);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_ovf", 32'(bus.overflow_o), 0);
    for (int k = 0; k < 4; k++) chk("rst_lane", lane(k), 32 + k);
    bus.alloc_en_i = 1'b1;
    step();
    bus.alloc_en_i = 1'b0;
    #1;
    chk("a4_count", 32'(bus.count_o), 28);
    chk("a4_lane0", lane(0), 36);

    // sparse request compaction
    do_reset();
    bus.alloc_valid_i = 4'b1010;
    #1;
    chk("sp_lane1", lane(1), 32);
    chk("sp_lane3", lane(3), 33);
    bus.alloc_en_i = 1'b1;
    step();
    bus.alloc_en_i = 1'b0;
    #1;
    chk("sp_count", 32'(bus.count_o), 30);

    // drain to empty, stall, free without bypass
    do_reset();
    bus.alloc_valid_i = 4'b1111;
    bus.alloc_en_i = 1'b1;
    repeat (8) step();
    chk("empty_count", 32'(bus.count_o), 0);
    bus.alloc_valid_i = 4'b0000;
    #1;
    chk("empty_nostall", 32'(bus.stall_o), 0);
    step();
    chk("empty_noop", 32'(bus.count_o), 0);
    bus.alloc_valid_i = 4'b0001;
    set_free(0, 40);
    #1;
    chk("empty_stall", 32'(bus.stall_o), 1);
    step();
    bus.free_valid_i = '0;
    #1;
    chk("refill_stall", 32'(bus.stall_o), 0);
    chk("refill_lane0", lane(0), 40);
    chk("refill_count", 32'(bus.count_o), 1);
    bus.alloc_en_i = 1'b0;

    // wrap-around across index 31 -> 0
    do_reset();
    bus.alloc_valid_i = 4'b1111;
    bus.alloc_en_i = 1'b1;
    repeat (7) step();
    bus.alloc_valid_i = 4'b0011;
    step();
    bus.alloc_en_i = 1'b0;
    bus.alloc_valid_i = '0;
    for (int j = 0; j < 4; j++) set_free(j, 50 + j);
    step();
    bus.free_valid_i = '0;
    bus.alloc_valid_i = 4'b1111;
    #1;
    chk("wrap_count", 32'(bus.count_o), 6);
    chk("wrap_l0", lane(0), 62);
    chk("wrap_l1", lane(1), 63);
    chk("wrap_l2", lane(2), 50);
    chk("wrap_l3", lane(3), 51);
    bus.alloc_en_i = 1'b1;
    step();
    bus.alloc_en_i = 1'b0;
    #1;
    chk("wrap_count2", 32'(bus.count_o), 2);
    chk("wrap_stall", 32'(bus.stall_o), 1);
    bus.alloc_valid_i = 4'b0011;
    #1;
    chk("wrap_l0b", lane(0), 52);
    chk("wrap_l1b", lane(1), 53);

    // simultaneous allocate and free at count 8
    do_reset();
    bus.alloc_valid_i = 4'b1111;
    bus.alloc_en_i = 1'b1;
    repeat (6) step();
    chk("sim_count0", 32'(bus.count_o), 8);
    for (int j = 0; j < 4; j++) set_free(j, 100 + j);
    #1;
    chk("sim_l0", lane(0), 56);
    step();
    bus.free_valid_i = '0;
    bus.alloc_en_i = 1'b0;
    #1;
    chk("sim_count1", 32'(bus.count_o), 8);
    for (int k = 0; k < 4; k++) chk("sim_old", lane(k), 60 + k);
    bus.alloc_en_i = 1'b1;
    step();
    bus.alloc_en_i = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk("sim_new", lane(k), 100 + k);
    chk("sim_count2", 32'(bus.count_o), 4);

    // over-free at full, sticky flag, async reset
    do_reset();
    bus.alloc_valid_i = 4'b1111;
    set_free(0, 5);
    set_free(1, 6);
    step();
    bus.free_valid_i = '0;
    #1;
    chk("of_count", 32'(bus.count_o), 32);
    chk("of_flag", 32'(bus.overflow_o), 1);
    chk("of_nowrite", lane(0), 32);
    step();
    chk("of_sticky", 32'(bus.overflow_o), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("of_rst_flag", 32'(bus.overflow_o), 0);
    chk("of_rst_count", 32'(bus.count_o), 32);

    // partial over-free: one slot left, two frees
    do_reset();
    bus.alloc_valid_i = 4'b0001;
    bus.alloc_en_i = 1'b1;
    step();
    bus.alloc_en_i = 1'b0;
    set_free(0, 90);
    set_free(1, 91);
    step();
    bus.free_valid_i = '0;
    #1;
    chk("pof_count", 32'(bus.count_o), 32);
    chk("pof_flag", 32'(bus.overflow_o), 1);
    chk("pof_head", lane(0), 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
